// File: rtl/mem_boot_loader_if.sv
// mem_boot_loader_if: byte stream input plus the RAM MFA/MOC write port of the boot loader
interface mem_boot_loader_if #(
    parameter int ADDR_W   = 9,
    parameter int IN_BYTES = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic [8*IN_BYTES-1:0] in_data;
    logic                  mem_mfa;
    logic                  mem_rw;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_wdata;
    logic                  mem_moc;

    modport master (
        input  in_valid, in_data, mem_moc,
        output in_ready, mem_mfa, mem_rw, mem_addr, mem_wdata
    );

    modport slave (
        output in_valid, in_data, mem_moc,
        input  in_ready, mem_mfa, mem_rw, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_boot_loader.sv
// mem_boot_loader: streams a byte-packed program image into byte-addressed RAM over MFA/MOC, holding the CPU until loaded
module mem_boot_loader #(
    parameter int ADDR_W      = 9,
    parameter int IN_BYTES    = 1,
    parameter bit BIG_ENDIAN  = 1'b1,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   byte_count,
    mem_boot_loader_if.master bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   bytes_loaded
);
    localparam int LW = IN_BYTES > 1 ? $clog2(IN_BYTES) : 1;
    localparam int TW = MOC_TIMEOUT > 0 ? $clog2(MOC_TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {IDLE, ACCEPT, WRITE, WAIT_MOC, DONE, ERR} state_t;

    state_t                state;
    logic [ADDR_W-1:0]     ptr;
    logic [ADDR_W:0]       remaining;
    logic [LW-1:0]         lane;
    logic [TW-1:0]         tmo;
    logic [8*IN_BYTES-1:0] beat;
    logic [8*IN_BYTES-1:0] ordered;
    logic                  last_byte;
    logic                  last_lane;

    // reorder the beat so lane 0 sits in the low byte; the writer then just shifts right
    for (genvar g = 0; g < IN_BYTES; g++) begin : g_lane
        assign ordered[8*g +: 8] = BIG_ENDIAN ? bus.in_data[8*(IN_BYTES-1-g) +: 8] : bus.in_data[8*g +: 8];
    end

    assign last_byte = remaining == (ADDR_W+1)'(1);
    assign last_lane = lane == LW'(IN_BYTES - 1);

    // loader FSM; every output is a register
    always_ff @(posedge clk) begin
        if (clear) begin
            state         <= IDLE;
            cpu_hold      <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            bytes_loaded  <= '0;
            bus.in_ready  <= 1'b0;
            bus.mem_mfa   <= 1'b0;
            bus.mem_rw    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            ptr           <= '0;
            remaining     <= '0;
            lane          <= '0;
            tmo           <= '0;
            beat          <= '0;
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    ptr          <= base_addr;
                    remaining    <= byte_count;
                    bytes_loaded <= '0;
                    done         <= byte_count == '0;
                    cpu_hold     <= byte_count != '0;
                    bus.in_ready <= byte_count != '0;
                    state        <= byte_count == '0 ? DONE : ACCEPT;
                end
                ACCEPT: if (bus.in_valid) begin
                    beat         <= ordered;
                    lane         <= '0;
                    bus.in_ready <= 1'b0;
                    state        <= WRITE;
                end
                WRITE: begin
                    bus.mem_addr  <= ptr;
                    bus.mem_wdata <= beat[7:0];
                    bus.mem_mfa   <= 1'b1;
                    bus.mem_rw    <= 1'b0;
                    tmo           <= '0;
                    state         <= WAIT_MOC;
                end
                WAIT_MOC: if (bus.mem_moc) begin
                    bus.mem_mfa  <= 1'b0;
                    ptr          <= ptr + 1'b1;
                    remaining    <= remaining - 1'b1;
                    bytes_loaded <= bytes_loaded + 1'b1;
                    beat         <= beat >> 8;
                    lane         <= lane + 1'b1;
                    done         <= last_byte;
                    cpu_hold     <= !last_byte;
                    bus.in_ready <= !last_byte && last_lane;
                    state        <= last_byte ? DONE : last_lane ? ACCEPT : WRITE;
                end else if (tmo == TW'(MOC_TIMEOUT)) begin
                    bus.mem_mfa <= 1'b0;
                    error       <= 1'b1;
                    state       <= ERR;
                end else begin
                    tmo <= tmo + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_boot_loader.sv
// tb_mem_boot_loader: scoreboard bench for the boot loader with byte-wide and 4-byte big/little-endian instances
module tb_mem_boot_loader;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       clear;
    logic       start;
    logic       start_w;
    logic [8:0] base_addr;
    logic [9:0] byte_count;
    logic       hold1, done1, err1, hold_b, done_b, err_b, hold_l, done_l, err_l;
    logic [9:0] bl1, bl_b, bl_l;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int moc_delay = 1;
    int wcnt      = 0;
    int rises     = 0;

    logic       held = 1'b0;
    logic [8:0] haddr, pa, pab, pal;
    logic [7:0] hdata, pd, pdb, pdl;
    logic [8:0] ea1[$], eab[$], eal[$];
    logic [7:0] ed1[$], edb[$], edl[$], src1[$];
    logic [31:0] srcw[$];

    mem_boot_loader_if #(.ADDR_W(9), .IN_BYTES(1)) b1 ();
    mem_boot_loader_if #(.ADDR_W(9), .IN_BYTES(4)) bb ();
    mem_boot_loader_if #(.ADDR_W(9), .IN_BYTES(4)) bl ();

    mem_boot_loader #(.ADDR_W(9), .IN_BYTES(1), .BIG_ENDIAN(1'b1), .MOC_TIMEOUT(15)) dut (
        .clk(clk), .clear(clear), .start(start), .base_addr(base_addr), .byte_count(byte_count),
        .bus(b1), .cpu_hold(hold1), .done(done1), .error(err1), .bytes_loaded(bl1)
    );

    mem_boot_loader #(.ADDR_W(9), .IN_BYTES(4), .BIG_ENDIAN(1'b1), .MOC_TIMEOUT(15)) dut_be (
        .clk(clk), .clear(clear), .start(start_w), .base_addr(base_addr), .byte_count(byte_count),
        .bus(bb), .cpu_hold(hold_b), .done(done_b), .error(err_b), .bytes_loaded(bl_b)
    );

    mem_boot_loader #(.ADDR_W(9), .IN_BYTES(4), .BIG_ENDIAN(1'b0), .MOC_TIMEOUT(15)) dut_le (
        .clk(clk), .clear(clear), .start(start_w), .base_addr(base_addr), .byte_count(byte_count),
        .bus(bl), .cpu_hold(hold_l), .done(done_l), .error(err_l), .bytes_loaded(bl_l)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // byte-wide RAM model: MOC after moc_delay cycles of MFA (0 = never), writes popped from the scoreboard
    always @(posedge clk) begin
        #1;
        if (b1.mem_mfa) begin
            checks++;
            if (b1.mem_rw !== 1'b0) begin
                failures++;
                $display("FAIL mem_rw got=%b want=0", b1.mem_rw);
            end
            if (held) begin
                checks++;
                if ({b1.mem_addr, b1.mem_wdata} !== {haddr, hdata}) begin
                    failures++;
                    $display("FAIL bus_stable got=%h/%h want=%h/%h", b1.mem_addr, b1.mem_wdata, haddr, hdata);
                end
            end else rises++;
            held = 1'b1; haddr = b1.mem_addr; hdata = b1.mem_wdata;
        end else held = 1'b0;
        if (b1.mem_mfa && !b1.mem_moc) begin
            wcnt++;
            if (moc_delay != 0 && wcnt >= moc_delay) begin
                b1.mem_moc = 1'b1;
                checks++;
                if (ea1.size() == 0) begin
                    failures++;
                    $display("FAIL write_unexpected got=%h@%h want=none", b1.mem_wdata, b1.mem_addr);
                end else begin
                    pa = ea1.pop_front(); pd = ed1.pop_front();
                    if ({b1.mem_addr, b1.mem_wdata} !== {pa, pd}) begin
                        failures++;
                        $display("FAIL write got=%h@%h want=%h@%h", b1.mem_wdata, b1.mem_addr, pd, pa);
                    end
                end
            end
        end else begin
            b1.mem_moc = 1'b0; wcnt = 0;
        end
    end

    // wide RAM models: MOC the cycle after MFA rises
    always @(posedge clk) begin
        #1;
        if (bb.mem_mfa && !bb.mem_moc) begin
            bb.mem_moc = 1'b1; checks++;
            if (eab.size() == 0) begin
                failures++;
                $display("FAIL be_write_unexpected got=%h@%h want=none", bb.mem_wdata, bb.mem_addr);
            end else begin
                pab = eab.pop_front(); pdb = edb.pop_front();
                if ({bb.mem_addr, bb.mem_wdata} !== {pab, pdb}) begin
                    failures++;
                    $display("FAIL be_write got=%h@%h want=%h@%h", bb.mem_wdata, bb.mem_addr, pdb, pab);
                end
            end
        end else bb.mem_moc = 1'b0;
        if (bl.mem_mfa && !bl.mem_moc) begin
            bl.mem_moc = 1'b1; checks++;
            if (eal.size() == 0) begin
                failures++;
                $display("FAIL le_write_unexpected got=%h@%h want=none", bl.mem_wdata, bl.mem_addr);
            end else begin
                pal = eal.pop_front(); pdl = edl.pop_front();
                if ({bl.mem_addr, bl.mem_wdata} !== {pal, pdl}) begin
                    failures++;
                    $display("FAIL le_write got=%h@%h want=%h@%h", bl.mem_wdata, bl.mem_addr, pdl, pal);
                end
            end
        end else bl.mem_moc = 1'b0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [8:0] a, input logic [7:0] d);
        src1.push_back(d); ea1.push_back(a); ed1.push_back(d);
    endtask

    task automatic pulse_start(input logic [8:0] base, input logic [9:0] cnt, input bit wide);
        base_addr = base; byte_count = cnt;
        if (wide) start_w = 1'b1; else start = 1'b1;
        step();
        start = 1'b0; start_w = 1'b0;
    endtask

    task automatic feed1(input bit toggle);
        bit ph = 1'b1;
        bit hs;
        int n = 0;
        while (src1.size() > 0 && n < 500) begin
            b1.in_valid = toggle ? ph : 1'b1; b1.in_data = src1[0]; ph = !ph;
            hs = b1.in_valid && b1.in_ready;
            step(); n++;
            if (hs) void'(src1.pop_front());
        end
        b1.in_valid = 1'b0;
        checks++;
        if (src1.size() != 0) begin
            failures++;
            $display("FAIL feed1_stall got=%0d left want=0", src1.size());
            src1.delete();
        end
    endtask

    task automatic feedw();
        bit hs;
        int n = 0;
        while (srcw.size() > 0 && n < 500) begin
            bb.in_valid = 1'b1; bl.in_valid = 1'b1; bb.in_data = srcw[0]; bl.in_data = srcw[0];
            hs = bb.in_ready && bl.in_ready;
            step(); n++;
            if (hs) void'(srcw.pop_front());
        end
        bb.in_valid = 1'b0; bl.in_valid = 1'b0;
        checks++;
        if (srcw.size() != 0) begin
            failures++;
            $display("FAIL feedw_stall got=%0d left want=0", srcw.size());
            srcw.delete();
        end
    endtask

    task automatic wait_done(input bit wide);
        int n = 0;
        while (!(wide ? (done_b && done_l) : done1) && n < 300) begin step(); n++; end
        checks++;
        if (!(wide ? (done_b && done_l) : done1)) begin
            failures++;
            $display("FAIL done_timeout got=0 want=1 wide=%0d", wide);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        step(); step();
        checks++;
        if ({b1.in_ready, b1.mem_mfa, b1.mem_rw, b1.mem_addr, b1.mem_wdata, done1, err1, bl1, hold1}
            !== {1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b1}) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h",
                {b1.in_ready, b1.mem_mfa, b1.mem_rw, b1.mem_addr, b1.mem_wdata, done1, err1, bl1, hold1},
                {1'b0, 1'b0, 1'b0, 9'd0, 8'd0, 1'b0, 1'b0, 10'd0, 1'b1});
        end
        checks++;
        if ({hold_b, hold_l, done_b, done_l, bb.mem_mfa, bl.mem_mfa} !== 6'b110000) begin
            failures++;
            $display("FAIL reset_wide got=%b want=110000", {hold_b, hold_l, done_b, done_l, bb.mem_mfa, bl.mem_mfa});
        end
        clear = 1'b0;
        repeat (3) step();
        checks++;
        if ({hold1, done1, b1.in_ready} !== 3'b100) begin
            failures++;
            $display("FAIL idle_hold got=%b want=100", {hold1, done1, b1.in_ready});
        end
    endtask

    task automatic test_count0();
        int r0 = rises;
        pulse_start(9'd5, 10'd0, 1'b0);
        checks++;
        if ({done1, hold1, bl1} !== {1'b1, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL count0_done got=%h want=%h", {done1, hold1, bl1}, {1'b1, 1'b0, 10'd0});
        end
        repeat (4) step();
        checks++;
        if (rises != r0 || b1.mem_mfa !== 1'b0 || done1 !== 1'b1) begin
            failures++;
            $display("FAIL count0_no_mfa got=rises%0d/mfa%b/done%b want=rises%0d/mfa0/done1", rises, b1.mem_mfa, done1, r0);
        end
    endtask

    task automatic test_basic();
        int s0;
        logic [7:0] img [4] = '{8'h8C, 8'h01, 8'h00, 8'h04};
        moc_delay = 1;
        foreach (img[i]) push1(9'(i), img[i]);
        pulse_start(9'd0, 10'd4, 1'b0);
        s0 = cyc;
        checks++;
        if ({done1, hold1, b1.in_ready} !== 3'b011) begin
            failures++;
            $display("FAIL basic_restart got=%b want=011", {done1, hold1, b1.in_ready});
        end
        feed1(1'b0);
        wait_done(1'b0);
        checks++;
        if (cyc - s0 != 12) begin
            failures++;
            $display("FAIL basic_latency got=%0d want=12", cyc - s0);
        end
        checks++;
        if ({hold1, bl1} !== {1'b0, 10'd4}) begin
            failures++;
            $display("FAIL basic_status got=%h want=%h", {hold1, bl1}, {1'b0, 10'd4});
        end
        checks++;
        if (ea1.size() != 0) begin
            failures++;
            $display("FAIL basic_pending got=%0d want=0", ea1.size());
        end
    endtask

    task automatic test_backpressure();
        moc_delay = 5;
        for (int i = 0; i < 5; i++) push1(9'(100 + i), 8'($urandom_range(0, 255)));
        pulse_start(9'd100, 10'd5, 1'b0);
        feed1(1'b1);
        wait_done(1'b0);
        checks++;
        if ({hold1, bl1} !== {1'b0, 10'd5}) begin
            failures++;
            $display("FAIL bp_status got=%h want=%h", {hold1, bl1}, {1'b0, 10'd5});
        end
        checks++;
        if (ea1.size() != 0) begin
            failures++;
            $display("FAIL bp_pending got=%0d want=0", ea1.size());
        end
    endtask

    task automatic test_wrap();
        moc_delay = 1;
        push1(9'd511, 8'hA5);
        push1(9'd0, 8'h5A);
        pulse_start(9'd511, 10'd2, 1'b0);
        feed1(1'b0);
        wait_done(1'b0);
        checks++;
        if (bl1 !== 10'd2 || ea1.size() != 0) begin
            failures++;
            $display("FAIL wrap got=%0d/%0d want=2/0", bl1, ea1.size());
        end
    endtask

    task automatic test_wide();
        logic [7:0] be [6] = '{8'h8C, 8'h01, 8'h00, 8'h04, 8'hAA, 8'hBB};
        logic [7:0] le [6] = '{8'h04, 8'h00, 8'h01, 8'h8C, 8'hDD, 8'hCC};
        srcw.push_back(32'h8C010004);
        srcw.push_back(32'hAABBCCDD);
        foreach (be[i]) begin
            eab.push_back(9'(i)); edb.push_back(be[i]);
            eal.push_back(9'(i)); edl.push_back(le[i]);
        end
        pulse_start(9'd0, 10'd6, 1'b1);
        feedw();
        wait_done(1'b1);
        checks++;
        if ({bl_b, bl_l} !== {10'd6, 10'd6}) begin
            failures++;
            $display("FAIL wide_count got=%0d/%0d want=6/6", bl_b, bl_l);
        end
        repeat (4) step();
        checks++;
        if (eab.size() + eal.size() != 0 || {bb.mem_mfa, bl.mem_mfa, hold_b, hold_l} !== 4'b0000) begin
            failures++;
            $display("FAIL wide_tail got=%0d/%0d/%b want=0/0/0000", eab.size(), eal.size(),
                {bb.mem_mfa, bl.mem_mfa, hold_b, hold_l});
        end
    endtask

    task automatic test_timeout();
        int t0;
        int n = 0;
        moc_delay = 0;
        push1(9'd20, 8'h77);
        pulse_start(9'd20, 10'd3, 1'b0);
        feed1(1'b0);
        while (!b1.mem_mfa && n < 20) begin step(); n++; end
        t0 = cyc;
        n = 0;
        while (b1.mem_mfa && n < 40) begin step(); n++; end
        checks++;
        if (cyc - t0 != 16) begin
            failures++;
            $display("FAIL timeout_len got=%0d want=16", cyc - t0);
        end
        checks++;
        if ({err1, hold1, done1, b1.mem_mfa} !== 4'b1100) begin
            failures++;
            $display("FAIL timeout_status got=%b want=1100", {err1, hold1, done1, b1.mem_mfa});
        end
        pulse_start(9'd0, 10'd0, 1'b0);
        repeat (3) step();
        checks++;
        if ({err1, hold1, done1, b1.in_ready, b1.mem_mfa} !== 5'b11000) begin
            failures++;
            $display("FAIL err_start_ignored got=%b want=11000", {err1, hold1, done1, b1.in_ready, b1.mem_mfa});
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if ({err1, hold1, done1} !== 3'b010) begin
            failures++;
            $display("FAIL err_clear got=%b want=010", {err1, hold1, done1});
        end
        ea1.delete(); ed1.delete();
    endtask

    task automatic test_clear_mid();
        int n = 0;
        moc_delay = 0;
        push1(9'd40, 8'h3C);
        pulse_start(9'd40, 10'd2, 1'b0);
        feed1(1'b0);
        while (!b1.mem_mfa && n < 20) begin step(); n++; end
        step(); step();
        checks++;
        if (b1.mem_mfa !== 1'b1) begin
            failures++;
            $display("FAIL clear_setup got=%b want=1", b1.mem_mfa);
        end
        clear = 1'b1;
        step();
        checks++;
        if ({b1.mem_mfa, hold1, done1, err1, b1.in_ready, bl1} !== {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0}) begin
            failures++;
            $display("FAIL clear_mid got=%h want=%h", {b1.mem_mfa, hold1, done1, err1, b1.in_ready, bl1},
                {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0});
        end
        clear = 1'b0;
        ea1.delete(); ed1.delete();
        moc_delay = 1;
        step();
        pulse_start(9'd0, 10'd0, 1'b0);
        checks++;
        if ({done1, hold1} !== 2'b10) begin
            failures++;
            $display("FAIL clear_idle got=%b want=10", {done1, hold1});
        end
    endtask

    initial begin
        clear = 1'b1; start = 1'b0; start_w = 1'b0; base_addr = '0; byte_count = '0;
        b1.in_valid = 1'b0; b1.in_data = '0;
        bb.in_valid = 1'b0; bb.in_data = '0;
        bl.in_valid = 1'b0; bl.in_data = '0;
        step();
        test_reset();
        test_count0();
        test_basic();
        test_backpressure();
        test_wrap();
        test_wide();
        test_timeout();
        test_clear_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1);
    end
endmodule
